// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and the game-grid geometry on screen.
// Shared by the sync generator and every renderer.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    localparam int VGA_DIV_PIXEL = 2;

    localparam int VGA_H_VISIVEL = 640;
    localparam int VGA_H_FRENTE  = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_TRAS    = 48;

    localparam int VGA_V_VISIVEL = 480;
    localparam int VGA_V_FRENTE  = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_TRAS    = 33;

    localparam logic VGA_SYNC_POL = 1'b0;

    localparam int GRADE_X0      = 16;
    localparam int GRADE_PASSO_X = 62;
    localparam int GRADE_Y0      = 16;
    localparam int GRADE_PASSO_Y = 57;
    localparam int CELULA_LARG   = 54;
    localparam int CELULA_ALT    = 49;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int soma_total(input int vis, input int frente,
                                      input int sinc, input int tras);
        return vis + frente + sinc + tras;
    endfunction

    localparam int VGA_H_TOTAL = soma_total(VGA_H_VISIVEL, VGA_H_FRENTE,
                                            VGA_H_SYNC, VGA_H_TRAS);
    localparam int VGA_V_TOTAL = soma_total(VGA_V_VISIVEL, VGA_V_FRENTE,
                                            VGA_V_SYNC, VGA_V_TRAS);

endpackage

// File: rtl/vga_div_pixel.sv
// Pixel-rate strobe: one clk high every DIV_PIXEL system clocks.
// The strobe comes straight from a flop so downstream sees no decode glitch.
module vga_div_pixel #(
    parameter int DIV_PIXEL = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pixelEn
);

    if (DIV_PIXEL <= 1) begin : g_direto
        logic unused_div;
        assign unused_div = clk ^ rst;
        assign pixelEn = 1'b1;
    end else begin : g_cont
        localparam int DW = $clog2(DIV_PIXEL);
        localparam logic [DW-1:0] ULTIMO = DW'(DIV_PIXEL - 1);

        logic [DW-1:0] div_q, div_d;
        logic          en_q, en_d;

        // en_q mirrors (div_q == ULTIMO) but is registered from div_d
        always_comb begin
            div_d = (div_q == ULTIMO) ? '0 : div_q + DW'(1);
            en_d  = (div_d == ULTIMO);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q <= '0;
                en_q  <= 1'b0;
            end else begin
                div_q <= div_d;
                en_q  <= en_d;
            end
        end

        assign pixelEn = en_q;
    end

endmodule

// File: rtl/vga_sincronismo.sv
// VGA raster timing: coordinates, active area, sync pulses, end-of-frame.
// Define VGA_CONTADOR_QUADROS_EN to add the 8-bit frame counter contQuadros.
module vga_sincronismo
    import vga_pkg::*;
#(
    parameter int   DIV_PIXEL = VGA_DIV_PIXEL,
    parameter int   H_VISIVEL = VGA_H_VISIVEL,
    parameter int   H_FRENTE  = VGA_H_FRENTE,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_TRAS    = VGA_H_TRAS,
    parameter int   V_VISIVEL = VGA_V_VISIVEL,
    parameter int   V_FRENTE  = VGA_V_FRENTE,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_TRAS    = VGA_V_TRAS,
    parameter logic SYNC_POL  = VGA_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pixelEn,
    output logic [COORD_W-1:0] coluna,
    output logic [COORD_W-1:0] linha,
    output logic               areaAtiva,
    output logic               hsync,
    output logic               vsync,
    output logic               fimQuadro
`ifdef VGA_CONTADOR_QUADROS_EN
    ,
    output logic [7:0]         contQuadros
`endif
);

    localparam int H_TOTAL = soma_total(H_VISIVEL, H_FRENTE, H_SYNC, H_TRAS);
    localparam int V_TOTAL = soma_total(V_VISIVEL, V_FRENTE, V_SYNC, V_TRAS);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_erro_total
        $error("vga_sincronismo: H_TOTAL/V_TOTAL exceed 1024");
    end

    localparam coord_t H_ULT    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_ULT    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_VISIVEL);
    localparam coord_t V_VIS    = coord_t'(V_VISIVEL);
    localparam coord_t HS_INI   = coord_t'(H_VISIVEL + H_FRENTE);
    localparam coord_t HS_FIM   = coord_t'(H_VISIVEL + H_FRENTE + H_SYNC - 1);
    localparam coord_t VS_INI   = coord_t'(V_VISIVEL + V_FRENTE);
    localparam coord_t VS_FIM   = coord_t'(V_VISIVEL + V_FRENTE + V_SYNC - 1);

    coord_t col_q, col_d;
    coord_t lin_q, lin_d;
    logic   area_q, area_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;

    vga_div_pixel #(
        .DIV_PIXEL (DIV_PIXEL)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .pixelEn (pixelEn)
    );

    // Flags are decoded from the next coordinates so they line up with them
    always_comb begin
        col_d = col_q;
        lin_d = lin_q;
        if (pixelEn) begin
            if (col_q == H_ULT) begin
                col_d = '0;
                lin_d = (lin_q == V_ULT) ? '0 : lin_q + coord_t'(1);
            end else begin
                col_d = col_q + coord_t'(1);
            end
        end
        area_d = (col_d < H_VIS) && (lin_d < V_VIS);
        hs_d   = (col_d >= HS_INI && col_d <= HS_FIM) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (lin_d >= VS_INI && lin_d <= VS_FIM) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= H_ULT;
            lin_q  <= V_ULT;
            area_q <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
        end else begin
            col_q  <= col_d;
            lin_q  <= lin_d;
            area_q <= area_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign coluna    = col_q;
    assign linha     = lin_q;
    assign areaAtiva = area_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign fimQuadro = pixelEn && (col_q == H_ULT) && (lin_q == V_ULT);

`ifdef VGA_CONTADOR_QUADROS_EN
    logic [7:0] quad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quad_q <= 8'd0;
        end else if (fimQuadro) begin
            quad_q <= quad_q + 8'd1;
        end
    end

    assign contQuadros = quad_q;
`endif

endmodule

// File: tb/tb_vga_sincronismo.sv
// Bench for vga_sincronismo: full-size instance for line-level timing,
// shrunken instance (active-high sync) for frame-level and frame counter.
module tb_vga_sincronismo;

    typedef struct packed {
        logic       pe;
        logic [9:0] col;
        logic [9:0] lin;
        logic       area;
        logic       hs;
        logic       vs;
        logic       fim;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    always #5 clk = ~clk;

    logic       pe0, area0, hs0, vs0, fim0;
    logic [9:0] col0, lin0;
    logic       pe1, area1, hs1, vs1, fim1;
    logic [9:0] col1, lin1;
`ifdef VGA_CONTADOR_QUADROS_EN
    logic [7:0] cq0, cq1;
`endif

    vga_sincronismo dut (
        .clk       (clk),
        .rst       (rst),
        .pixelEn   (pe0),
        .coluna    (col0),
        .linha     (lin0),
        .areaAtiva (area0),
        .hsync     (hs0),
        .vsync     (vs0),
        .fimQuadro (fim0)
`ifdef VGA_CONTADOR_QUADROS_EN
        ,
        .contQuadros (cq0)
`endif
    );

    vga_sincronismo #(
        .DIV_PIXEL (2),
        .H_VISIVEL (8), .H_FRENTE (1), .H_SYNC (2), .H_TRAS (1),
        .V_VISIVEL (6), .V_FRENTE (1), .V_SYNC (2), .V_TRAS (1),
        .SYNC_POL  (1'b1)
    ) dut_s (
        .clk       (clk),
        .rst       (rst_s),
        .pixelEn   (pe1),
        .coluna    (col1),
        .linha     (lin1),
        .areaAtiva (area1),
        .hsync     (hs1),
        .vsync     (vs1),
        .fimQuadro (fim1)
`ifdef VGA_CONTADOR_QUADROS_EN
        ,
        .contQuadros (cq1)
`endif
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 0;

    // k = clock edges since reset release; pixel advances on every 2nd edge
    function automatic exp_t model(input int k,
                                   input int hv, input int hf, input int hs,
                                   input int hb, input int vv, input int vf,
                                   input int vs, input int vb, input bit pol);
        exp_t e;
        int ht, vt, f, n, idx, c, l;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        f = ht * vt;
        n = k / 2;
        idx = (f - 1 + (n % f)) % f;
        c = idx % ht;
        l = idx / ht;
        e.pe = (k % 2) == 1;
        e.col = c[9:0];
        e.lin = l[9:0];
        e.area = (c < hv) && (l < vv);
        e.hs = (c >= hv + hf && c < hv + hf + hs) ? pol : !pol;
        e.vs = (l >= vv + vf && l < vv + vf + vs) ? pol : !pol;
        e.fim = e.pe && (c == ht - 1) && (l == vt - 1);
        return e;
    endfunction

    int k0 = 0;
    int k1 = 0;
    int cqm = 0;
    exp_t e0, e1;

    always_comb e0 = model(k0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    always_comb e1 = model(k1, 8, 1, 2, 1, 6, 1, 2, 1, 1'b1);

    always @(posedge clk or posedge rst)
        if (rst) k0 <= 0;
        else k0 <= k0 + 1;

    always @(posedge clk or posedge rst_s)
        if (rst_s) k1 <= 0;
        else k1 <= k1 + 1;

    always @(posedge clk or posedge rst_s)
        if (rst_s) cqm <= 0;
        else if (e1.fim) cqm <= (cqm + 1) % 256;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("d_pixelEn", pe0, e0.pe);
            chk("d_coluna", col0, e0.col);
            chk("d_linha", lin0, e0.lin);
            chk("d_areaAtiva", area0, e0.area);
            chk("d_hsync", hs0, e0.hs);
            chk("d_vsync", vs0, e0.vs);
            chk("d_fimQuadro", fim0, e0.fim);
            chk("s_pixelEn", pe1, e1.pe);
            chk("s_coluna", col1, e1.col);
            chk("s_linha", lin1, e1.lin);
            chk("s_areaAtiva", area1, e1.area);
            chk("s_hsync", hs1, e1.hs);
            chk("s_vsync", vs1, e1.vs);
            chk("s_fimQuadro", fim1, e1.fim);
`ifdef VGA_CONTADOR_QUADROS_EN
            chk("s_contQuadros", cq1, cqm);
            chk("d_contQuadros_nz", cq0 <= 8'd1, 1);
`endif
        end
    end

    int nfim = 0;
    int nvs = 0;

    always @(negedge clk)
        if (!rst_s && k1 >= 1) begin
            if (fim1) nfim++;
            if (vs1) nvs++;
        end

    initial begin
        int cnt;
        int fallc;
        int guard;
        rst = 1'b1;
        rst_s = 1'b1;
        #1 chk_on = 1;
        repeat (3) @(negedge clk);

        chk("rst_coluna", col0, 799);
        chk("rst_linha", lin0, 524);
        chk("rst_area", area0, 0);
        chk("rst_hsync", hs0, 1);
        chk("rst_vsync", vs0, 1);
        chk("rst_pixelEn", pe0, 0);
        chk("rst_fim", fim0, 0);

        rst = 1'b0;
        rst_s = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("e1_pixelEn", pe0, 1);
        chk("e1_fim", fim0, 1);
        @(posedge clk);
        @(negedge clk);
        chk("e2_coluna", col0, 0);
        chk("e2_linha", lin0, 0);
        chk("e2_area", area0, 1);
        chk("e2_hsync", hs0, 1);
        chk("e2_vsync", vs0, 1);

        cnt = 0;
        fallc = -1;
        for (int i = 0; i < 1600; i++) begin
            if (!hs0) cnt++;
            if (!area0 && fallc < 0) fallc = int'(col0);
            @(negedge clk);
        end
        chk("line_hsync_low_clks", cnt, 192);
        chk("line_area_fall_col", fallc, 640);
        chk("wrap_coluna", col0, 0);
        chk("wrap_linha", lin0, 1);
        chk("wrap_area", area0, 1);

        repeat (600) @(posedge clk);
        #1;
        chk("pre_rst_coluna", col0, 300);
        chk("pre_rst_linha", lin0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_coluna", col0, 799);
        chk("async_linha", lin0, 524);
        chk("async_area", area0, 0);
        chk("async_hsync", hs0, 1);
        chk("async_vsync", vs0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("re_e1_pixelEn", pe0, 1);
        @(posedge clk);
        @(negedge clk);
        chk("re_e2_coluna", col0, 0);
        chk("re_e2_linha", lin0, 0);
        chk("re_e2_area", area0, 1);

        guard = 0;
        while (k1 < 61441 && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        chk("s_reach_timeout", k1, 61441);
        chk("s_corner_fim", fim1, 1);
        chk("s_corner_col", col1, 11);
        chk("s_corner_lin", lin1, 9);
`ifdef VGA_CONTADOR_QUADROS_EN
        chk("s_cont_wrap", cq1, 0);
`endif
        @(negedge clk);
        #1;
        chk("s_next_col", col1, 0);
        chk("s_next_lin", lin1, 0);
        chk("s_fim_count", nfim, 257);
        chk("s_vsync_clks", nvs, 12288);
`ifdef VGA_CONTADOR_QUADROS_EN
        chk("s_cont_after_wrap", cq1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
